// File: rtl/j1_uart.sv
// J1 I/O-bus UART: 16-deep TX FIFO with 8N1 serialiser, single-byte RX holding register.
// State | meaning: IDLE line idle | START start bit | DATA 8 data bits LSB first | STOP stop bit
module j1_uart #(
    parameter logic [15:0] BASE     = 16'h6400,
    parameter int          BAUD_DIV = 590,
    parameter int          FIFO_AW  = 4
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_n_i,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_dout,
    output logic [15:0] io_din_o,
    output logic        sel_o,
    output logic        uart_txd_o,
    input  logic        uart_rxd_i
);
    localparam int          DEPTH   = 1 << FIFO_AW;
    localparam logic [11:0] BIT_LD  = 12'(BAUD_DIV - 1);
    localparam logic [11:0] HALF_LD = 12'(BAUD_DIV / 2 - 1);
    localparam logic [15:0] A_TX    = BASE;
    localparam logic [15:0] A_ST    = BASE + 16'd2;
    localparam logic [15:0] A_RX    = BASE + 16'd4;
    localparam logic [15:0] A_CTRL  = BASE + 16'd6;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [7:0]       r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr, r_rptr;
    logic [FIFO_AW:0] r_count;
    state_t           r_tx_state, r_rx_state;
    logic [11:0]      r_tx_cnt, r_rx_cnt;
    logic [2:0]       r_tx_bit, r_rx_bit;
    logic [7:0]       r_tx_shift, r_rx_shift, r_rx_byte;
    logic             r_txd, r_rx_s1, r_rx_s2;
    logic             r_rx_valid, r_rx_ovr, r_rx_ferr, r_tx_ovf;

    logic w_full, w_empty, w_wr_tx, w_rd_st, w_rd_rx, w_flush;
    logic w_push, w_pop, w_tx_adv, w_rx_adv, w_busy;
    logic w_unused_dout;

    // count never exceeds DEPTH, so its MSB alone flags full
    assign w_full   = r_count[FIFO_AW];
    assign w_empty  = (r_count == '0);
    assign w_wr_tx  = io_wr && (io_addr == A_TX);
    assign w_rd_st  = io_rd && (io_addr == A_ST);
    assign w_rd_rx  = io_rd && (io_addr == A_RX);
    assign w_flush  = io_wr && (io_addr == A_CTRL) && io_dout[0];
    assign w_tx_adv = (r_tx_cnt == 12'd0);
    assign w_rx_adv = (r_rx_cnt == 12'd0);
    assign w_push   = w_wr_tx && !w_full && !w_flush;
    assign w_pop    = !w_empty && ((r_tx_state == S_IDLE) || (r_tx_state == S_STOP && w_tx_adv));
    assign w_busy   = (r_tx_state != S_IDLE);
    assign w_unused_dout = ^io_dout[15:8];

    always_ff @(posedge sys_clk_i) begin
        if (w_push) r_mem[r_wptr] <= io_dout[7:0];
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    // txd is registered from the current state, so the whole frame lags the FSM by one cycle
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_txd <= (r_tx_state == S_START) ? 1'b0 :
                     (r_tx_state == S_DATA)  ? r_tx_shift[0] : 1'b1;
            case (r_tx_state)
                S_IDLE: if (w_pop) begin
                    r_tx_shift <= r_mem[r_rptr];
                    r_tx_cnt   <= BIT_LD;
                    r_tx_state <= S_START;
                end
                S_START: if (w_tx_adv) begin
                    r_tx_cnt   <= BIT_LD;
                    r_tx_bit   <= '0;
                    r_tx_state <= S_DATA;
                end else r_tx_cnt <= r_tx_cnt - 1'b1;
                S_DATA: if (w_tx_adv) begin
                    r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                    r_tx_bit   <= r_tx_bit + 1'b1;
                    r_tx_cnt   <= BIT_LD;
                    if (r_tx_bit == 3'd7) r_tx_state <= S_STOP;
                end else r_tx_cnt <= r_tx_cnt - 1'b1;
                S_STOP: if (w_tx_adv) begin
                    if (w_pop) begin
                        r_tx_shift <= r_mem[r_rptr];
                        r_tx_cnt   <= BIT_LD;
                        r_tx_state <= S_START;
                    end else r_tx_state <= S_IDLE;
                end else r_tx_cnt <= r_tx_cnt - 1'b1;
                default: r_tx_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
        end else begin
            r_rx_s1 <= uart_rxd_i;
            r_rx_s2 <= r_rx_s1;
        end
    end

    // later assignments win, so a same-edge load or error beats the read-clear
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_byte  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_ovr   <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            if (w_rd_rx) r_rx_valid <= 1'b0;
            if (w_rd_st) begin
                r_rx_ovr  <= 1'b0;
                r_rx_ferr <= 1'b0;
            end
            case (r_rx_state)
                S_IDLE: if (!r_rx_s2) begin
                    r_rx_cnt   <= HALF_LD;
                    r_rx_state <= S_START;
                end
                S_START: if (w_rx_adv) begin
                    if (!r_rx_s2) begin
                        r_rx_cnt   <= BIT_LD;
                        r_rx_bit   <= '0;
                        r_rx_state <= S_DATA;
                    end else r_rx_state <= S_IDLE;
                end else r_rx_cnt <= r_rx_cnt - 1'b1;
                S_DATA: if (w_rx_adv) begin
                    r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                    r_rx_bit   <= r_rx_bit + 1'b1;
                    r_rx_cnt   <= BIT_LD;
                    if (r_rx_bit == 3'd7) r_rx_state <= S_STOP;
                end else r_rx_cnt <= r_rx_cnt - 1'b1;
                S_STOP: if (w_rx_adv) begin
                    r_rx_state <= S_IDLE;
                    if (r_rx_s2) begin
                        if (!r_rx_valid || w_rd_rx) begin
                            r_rx_byte  <= r_rx_shift;
                            r_rx_valid <= 1'b1;
                        end else r_rx_ovr <= 1'b1;
                    end else r_rx_ferr <= 1'b1;
                end else r_rx_cnt <= r_rx_cnt - 1'b1;
                default: r_rx_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i)             r_tx_ovf <= 1'b0;
        else if (w_wr_tx && w_full)   r_tx_ovf <= 1'b1;
        else if (w_rd_st)             r_tx_ovf <= 1'b0;
    end

    always_comb begin
        io_din_o = 16'h0000;
        if (io_addr == A_ST)
            io_din_o = {9'd0, r_rx_ferr, r_rx_ovr, r_tx_ovf, r_rx_valid, w_busy, w_empty, w_full};
        else if (io_addr == A_RX)
            io_din_o = {8'h00, r_rx_byte};
    end

    assign sel_o      = (io_addr == A_TX) || (io_addr == A_ST) || (io_addr == A_RX) || (io_addr == A_CTRL);
    assign uart_txd_o = r_txd;
endmodule

// File: tb/tb_j1_uart.sv
// Scoreboard bench for j1_uart: queue-level TX/RX reference model, serial TX monitor, bus read monitor.
module tb_j1_uart;
    localparam int          BD    = 4;
    localparam int          FRAME = 10 * BD;
    localparam logic [15:0] BASE  = 16'h6400;
    localparam logic [15:0] A_TX  = BASE;
    localparam logic [15:0] A_ST  = BASE + 16'd2;
    localparam logic [15:0] A_RX  = BASE + 16'd4;
    localparam logic [15:0] A_CTRL = BASE + 16'd6;

    logic        clk = 1'b0, rst_n = 1'b0, io_rd = 1'b0, io_wr = 1'b0, uart_rxd_i = 1'b1;
    logic [15:0] io_addr = 16'h0, io_dout = 16'h0;
    logic [15:0] io_din_o;
    logic        sel_o, uart_txd_o;

    always #5 clk = ~clk;

    j1_uart #(.BASE(BASE), .BAUD_DIV(BD), .FIFO_AW(4)) dut (
        .sys_clk_i(clk), .sys_rst_n_i(rst_n), .io_rd(io_rd), .io_wr(io_wr),
        .io_addr(io_addr), .io_dout(io_dout), .io_din_o(io_din_o), .sel_o(sel_o),
        .uart_txd_o(uart_txd_o), .uart_rxd_i(uart_rxd_i));

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct { logic [7:0] b; int fall; } txe_t;
    typedef struct { logic [15:0] a; logic [15:0] d; } rde_t;
    txe_t       exp_q[$];
    rde_t       rd_q[$];
    logic [7:0] m_fifo[$];
    int         cyc = 0, m_free = 0, epoch = 0;
    logic       m_ovf = 1'b0, m_rxv = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0;
    logic [7:0] m_rxb = 8'h00;

    // TX reference: a pop starts a frame when the FIFO holds data and the previous frame is over
    always @(posedge clk) begin : model
        logic pop, wr, fl, full;
        txe_t t;
        cyc = cyc + 1;
        if (!rst_n) begin
            m_fifo.delete();
            exp_q.delete();
            m_free = 0;
            m_ovf  = 1'b0;
        end else begin
            pop  = (m_fifo.size() != 0) && (cyc >= m_free);
            wr   = io_wr && (io_addr == A_TX);
            fl   = io_wr && (io_addr == A_CTRL) && io_dout[0];
            full = (m_fifo.size() == 16);
            if (io_rd && io_addr == A_ST) m_ovf = 1'b0;
            if (wr && full) m_ovf = 1'b1;
            if (pop) begin
                t.b = m_fifo.pop_front();
                t.fall = cyc + 1;
                exp_q.push_back(t);
                m_free = cyc + FRAME;
            end
            if (fl) m_fifo.delete();
            else if (wr && !full) m_fifo.push_back(io_dout[7:0]);
        end
    end

    always @(negedge rst_n) epoch = epoch + 1;

    initial begin : tx_mon
        int f, ep;
        logic [7:0] b;
        logic st0, sp;
        txe_t t;
        forever begin
            @(negedge clk);
            if (rst_n && uart_txd_o === 1'b0) begin
                f = cyc;
                ep = epoch;
                repeat (2) @(negedge clk);
                st0 = uart_txd_o;
                for (int i = 0; i < 8; i++) begin
                    repeat (BD) @(negedge clk);
                    b[i] = uart_txd_o;
                end
                repeat (BD) @(negedge clk);
                sp = uart_txd_o;
                if (ep == epoch) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL tx_frame: unexpected frame byte %h, none expected", b);
                    end else begin
                        t = exp_q.pop_front();
                        chk("tx_start_bit", {31'd0, st0}, 32'd0);
                        chk("tx_byte", {24'd0, b}, {24'd0, t.b});
                        chk("tx_stop_bit", {31'd0, sp}, 32'd1);
                        chk("tx_fall_cycle", f, t.fall);
                    end
                end
            end
        end
    end

    function automatic logic exp_sel(input logic [15:0] a);
        return (a == A_TX) || (a == A_ST) || (a == A_RX) || (a == A_CTRL);
    endfunction

    initial begin : rd_mon
        rde_t r;
        forever begin
            @(negedge clk);
            #2;
            if (io_rd) begin
                if (rd_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL rd_unexpected: read of %h with nothing expected", io_addr);
                end else begin
                    r = rd_q.pop_front();
                    chk($sformatf("rd_data@%h", r.a), {16'd0, io_din_o}, {16'd0, r.d});
                    chk($sformatf("rd_sel@%h", r.a), {31'd0, sel_o}, {31'd0, exp_sel(r.a)});
                end
            end
        end
    end

    function automatic logic [15:0] exp_status();
        return {9'd0, m_ferr, m_ovr, m_ovf, m_rxv, (cyc < m_free),
                (m_fifo.size() == 0), (m_fifo.size() == 16)};
    endfunction

    task automatic bus_read(input logic [15:0] a);
        rde_t r;
        @(negedge clk);
        io_rd = 1'b1;
        io_addr = a;
        r.a = a;
        r.d = (a == A_ST) ? exp_status() : (a == A_RX) ? {8'h00, m_rxb} : 16'h0000;
        rd_q.push_back(r);
        @(posedge clk);
        #1 io_rd = 1'b0;
        if (a == A_ST) begin
            m_ovr = 1'b0;
            m_ferr = 1'b0;
        end
        if (a == A_RX) m_rxv = 1'b0;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        io_wr = 1'b1;
        io_addr = a;
        io_dout = d;
        @(posedge clk);
        #1 io_wr = 1'b0;
    endtask

    task automatic wait_tx_idle(input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || m_fifo.size() != 0 || cyc < m_free + 2) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("tx_drain_in_time", {31'd0, (n < limit)}, 32'd1);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            uart_rxd_i = fr[i];
            repeat (BD - 1) @(negedge clk);
        end
        @(negedge clk);
        uart_rxd_i = 1'b1;
        repeat (12) @(negedge clk);
        if (stop) begin
            if (!m_rxv) begin
                m_rxv = 1'b1;
                m_rxb = b;
            end else m_ovr = 1'b1;
        end else m_ferr = 1'b1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

    initial begin : main
        logic [7:0] b;
        repeat (3) @(negedge clk);
        chk("txd_in_reset", {31'd0, uart_txd_o}, 32'd1);
        rst_n = 1'b1;
        bus_read(A_ST);
        bus_read(A_RX);
        bus_read(BASE + 16'h8);
        chk("txd_idle", {31'd0, uart_txd_o}, 32'd1);

        bus_write(A_TX, 16'h00A5);
        repeat (10) @(negedge clk);
        bus_read(A_ST);
        wait_tx_idle(200);
        bus_read(A_ST);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            io_wr = 1'b1;
            io_addr = A_TX;
            io_dout = {8'h00, 8'($urandom)};
        end
        @(posedge clk);
        #1 io_wr = 1'b0;
        bus_read(A_ST);
        bus_read(A_ST);
        wait_tx_idle(1200);
        bus_read(A_ST);

        for (int i = 0; i < 5; i++) bus_write(A_TX, {8'h00, 8'($urandom)});
        bus_write(A_CTRL, 16'h0001);
        bus_read(A_ST);
        wait_tx_idle(200);
        bus_write(A_ST, 16'hFFFF);
        bus_read(A_ST);

        send_rx(8'h3C, 1'b1);
        bus_read(A_ST);
        bus_read(A_RX);
        bus_read(A_ST);
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            send_rx(b, 1'b1);
            bus_read(A_RX);
            bus_read(A_RX);
        end
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        bus_read(A_ST);
        bus_read(A_RX);
        bus_read(A_ST);
        send_rx(8'($urandom), 1'b0);
        repeat (10) @(negedge clk);
        bus_read(A_ST);
        bus_read(A_ST);
        @(negedge clk);
        uart_rxd_i = 1'b0;
        @(negedge clk);
        uart_rxd_i = 1'b1;
        repeat (60) @(negedge clk);
        bus_read(A_ST);
        send_rx(8'h5A, 1'b1);

        bus_write(A_TX, 16'h0000);
        bus_write(A_TX, 16'h00FF);
        repeat (15) @(negedge clk);
        #3 rst_n = 1'b0;
        #1 chk("txd_async_reset", {31'd0, uart_txd_o}, 32'd1);
        m_rxv = 1'b0;
        m_rxb = 8'h00;
        m_ovr = 1'b0;
        m_ferr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        bus_read(A_ST);
        bus_read(A_RX);
        bus_write(A_TX, {8'h00, 8'($urandom)});
        wait_tx_idle(200);
        bus_read(A_ST);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
